serial_word_tx: RTL and testbench

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

---
 rtl/serial_word_tx.sv | 147 ++++++++++++++
 tb/tb_serial_word_tx.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// ---------------------------------------------------------------------------
// serial_word_tx
//   Parallel-to-serial word transmitter. A WORD_WIDTH-bit word is accepted on
//   a valid/ready handshake and shifted out MSB first, one bit per clock,
//   with an optional idle gap of GAP_CYCLES cycles between words.
//
// Handshake: a word transfers on a rising clk edge where word_in_valid and
//   word_in_ready are both 1 and clr is 0. word_in_ready never depends on
//   word_in_valid, so the source may hold valid high for as long as it wants.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   clr            synchronous clear, same effect as reset
//   word_in        parallel word to transmit
//   word_in_valid  word_in holds a word
//   word_in_ready  block accepts word_in this cycle
//   bit_out        serial data bit (0 whenever bit_out_valid is 0)
//   bit_out_valid  bit_out carries a data bit
//   bit_last       bit_out is the final bit of a word
//   busy           shifting or gap in progress
// ---------------------------------------------------------------------------
module serial_word_tx #(
  parameter int WORD_WIDTH = 412,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_in_valid,
  output logic                  word_in_ready,
  output logic                  bit_out,
  output logic                  bit_out_valid,
  output logic                  bit_last,
  output logic                  busy
);

  localparam int CW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         gap_q, gap_d;

  logic is_last;
  logic accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    // Output defaults correspond to IDLE.
    word_in_ready = 1'b0;
    bit_out       = 1'b0;
    bit_out_valid = 1'b0;
    bit_last      = 1'b0;
    busy          = 1'b0;
    is_last       = (cnt_q == CNT_LAST);

    case (state_q)
      ST_IDLE: begin
        word_in_ready = 1'b1;
      end
      ST_SHIFT: begin
        bit_out_valid = 1'b1;
        bit_out       = shift_q[WORD_WIDTH-1];
        bit_last      = is_last;
        busy          = 1'b1;
        // Without a gap the next word may load while the last bit is out,
        // giving a gapless stream.
        word_in_ready = is_last && (GAP_CYCLES == 0);
      end
      ST_GAP: begin
        busy = 1'b1;
      end
      default: begin
      end
    endcase

    // clr wins over a same-cycle handshake; the offered word is dropped.
    accept = word_in_valid && word_in_ready && !clr;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;

    if (clr) begin
      state_d = ST_IDLE;
      shift_d = '0;
      cnt_d   = '0;
      gap_d   = '0;
    end else if (accept) begin
      // Every acceptance restarts the bit counter, so it can never wrap.
      state_d = ST_SHIFT;
      shift_d = word_in;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          shift_d = shift_q << 1;
          if (is_last) begin
            cnt_d   = '0;
            gap_d   = '0;
            state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_word_tx
//   Directed bench for serial_word_tx. Three instances share clock and reset:
//   u0 (8 bits, no gap), u3 (8 bits, 3-cycle gap) and uw (412 bits, no gap)
//   which feeds a serial-to-parallel receiver for the loopback scenario.
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_serial_word_tx;

  localparam int WW = 412;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  // u0: WORD_WIDTH=8, GAP_CYCLES=0
  logic       clr0, v0, r0, b0, bv0, bl0, busy0;
  logic [7:0] w0;
  // u3: WORD_WIDTH=8, GAP_CYCLES=3
  logic       clr3, v3, r3, b3, bv3, bl3, busy3;
  logic [7:0] w3;
  // uw: WORD_WIDTH=412, GAP_CYCLES=0
  logic          vw, rw, bw, bvw, blw, busyw;
  logic [WW-1:0] ww;

  serial_word_tx #(.WORD_WIDTH(8), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .word_in(w0), .word_in_valid(v0),
    .word_in_ready(r0), .bit_out(b0), .bit_out_valid(bv0), .bit_last(bl0),
    .busy(busy0)
  );

  serial_word_tx #(.WORD_WIDTH(8), .GAP_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .clr(clr3), .word_in(w3), .word_in_valid(v3),
    .word_in_ready(r3), .bit_out(b3), .bit_out_valid(bv3), .bit_last(bl3),
    .busy(busy3)
  );

  serial_word_tx #(.WORD_WIDTH(WW), .GAP_CYCLES(0)) uw (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .word_in(ww), .word_in_valid(vw),
    .word_in_ready(rw), .bit_out(bw), .bit_out_valid(bvw), .bit_last(blw),
    .busy(busyw)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback receiver and scoreboard: shifts left on every valid bit and
  // compares the assembled word against the oldest word sent.
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] rx_sr;
  int            rx_count;

  always @(negedge clk) begin
    logic [WW-1:0] rx_next;
    if (rst_n && bvw) begin
      rx_next = {rx_sr[WW-2:0], bw};
      rx_sr   = rx_next;
      if (blw) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL loopback_extra_word: got word %0d, required none", rx_count);
        end else begin
          logic [WW-1:0] e;
          e = exp_q.pop_front();
          if (rx_next !== e) begin
            n_fail++;
            $display("FAIL loopback_word%0d: got %h, required %h", rx_count, rx_next, e);
          end
        end
        rx_count++;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    clr0 = 0; v0 = 0; w0 = '0;
    clr3 = 0; v3 = 0; w3 = '0;
    vw = 0; ww = '0;
    #2;
    // Outputs must be valid during reset before any clock edge.
    n_checks++;
    if ({r0, b0, bv0, bl0, busy0} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_u0: got rdy,bit,vld,last,busy=%b, required 10000", {r0, b0, bv0, bl0, busy0});
    end
    n_checks++;
    if ({r3, b3, bv3, bl3, busy3} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_u3: got %b, required 10000", {r3, b3, bv3, bl3, busy3});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] e;
    e = 8'hA5;
    @(negedge clk);
    w0 = e; v0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v0 = 1'b0;
      n_checks++;
      if (bv0 !== 1'b1 || b0 !== e[7-i] || bl0 !== (i == 7)) begin
        n_fail++;
        $display("FAIL single_bit%0d: got vld=%b bit=%b last=%b, required vld=1 bit=%b last=%b",
                 i, bv0, b0, bl0, e[7-i], (i == 7));
      end
    end
    @(negedge clk);
    n_checks++;
    if ({r0, b0, bv0, bl0, busy0} !== 5'b10000) begin
      n_fail++;
      $display("FAIL single_idle: got %b, required 10000", {r0, b0, bv0, bl0, busy0});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    e = 16'h817E;
    @(negedge clk);
    w0 = 8'h81; v0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      // Word changes while not ready must be ignored; 0x7E is taken at the
      // last bit of 0x81.
      if (i == 0) w0 = 8'h7E;
      if (i == 8) v0 = 1'b0;
      n_checks++;
      if (bv0 !== 1'b1 || b0 !== e[15-i] || bl0 !== (i == 7 || i == 15)) begin
        n_fail++;
        $display("FAIL b2b_bit%0d: got vld=%b bit=%b last=%b, required vld=1 bit=%b last=%b",
                 i, bv0, b0, bl0, e[15-i], (i == 7 || i == 15));
      end
      if (i == 3 || i == 7) begin
        n_checks++;
        if (r0 !== (i == 7)) begin
          n_fail++;
          $display("FAIL b2b_ready%0d: got %b, required %b", i, r0, (i == 7));
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if ({r0, bv0, busy0} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_idle: got rdy,vld,busy=%b, required 100", {r0, bv0, busy0});
    end
  endtask

  task automatic test_gap();
    logic [15:0] e;
    e = 16'h3CC3;
    @(negedge clk);
    w3 = 8'h3C; v3 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (i == 0) begin
          if (k == 0) w3 = 8'hC3;
          else v3 = 1'b0;
        end
        n_checks++;
        if (bv3 !== 1'b1 || b3 !== e[15-(8*k+i)] || bl3 !== (i == 7) || r3 !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_w%0d_bit%0d: got vld=%b bit=%b last=%b rdy=%b, required 1 %b %b 0",
                   k, i, bv3, b3, bl3, r3, e[15-(8*k+i)], (i == 7));
        end
      end
      for (int g = 0; g < 3; g++) begin
        @(negedge clk);
        n_checks++;
        if ({r3, b3, bv3, busy3} !== 4'b0001) begin
          n_fail++;
          $display("FAIL gap_w%0d_gap%0d: got rdy,bit,vld,busy=%b, required 0001", k, g, {r3, b3, bv3, busy3});
        end
      end
      @(negedge clk);
      n_checks++;
      if ({r3, bv3, busy3} !== 3'b100) begin
        n_fail++;
        $display("FAIL gap_w%0d_idle: got rdy,vld,busy=%b, required 100", k, {r3, bv3, busy3});
      end
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] e;
    @(negedge clk);
    w0 = 8'hFF; v0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v0 = 1'b0;
      n_checks++;
      if (bv0 !== 1'b1 || b0 !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_ff_bit%0d: got vld=%b bit=%b, required 1 1", i, bv0, b0);
      end
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({r0, b0, bv0, bl0, busy0} !== 5'b10000) begin
      n_fail++;
      $display("FAIL rst_midword: got %b, required 10000", {r0, b0, bv0, bl0, busy0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    e = 8'h0F;
    w0 = e; v0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v0 = 1'b0;
      n_checks++;
      if (bv0 !== 1'b1 || b0 !== e[7-i] || bl0 !== (i == 7)) begin
        n_fail++;
        $display("FAIL rst_0f_bit%0d: got vld=%b bit=%b last=%b, required 1 %b %b",
                 i, bv0, b0, bl0, e[7-i], (i == 7));
      end
    end
  endtask

  task automatic test_clr();
    @(negedge clk);
    // clr with a valid word in IDLE: nothing is accepted.
    w0 = 8'hAA; v0 = 1'b1; clr0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0; clr0 = 1'b0;
    n_checks++;
    if ({r0, bv0, busy0} !== 3'b100) begin
      n_fail++;
      $display("FAIL clr_idle: got rdy,vld,busy=%b, required 100", {r0, bv0, busy0});
    end
    // clr mid-word aborts without bit_last.
    w0 = 8'hAA; v0 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      v0 = 1'b0;
    end
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    n_checks++;
    if ({r0, b0, bv0, bl0, busy0} !== 5'b10000) begin
      n_fail++;
      $display("FAIL clr_midword: got %b, required 10000", {r0, b0, bv0, bl0, busy0});
    end
  endtask

  task automatic test_loopback();
    logic [WW-1:0] w;
    int            budget;
    logic          acc;
    rx_count = 0;
    rx_sr    = '0;
    for (int k = 0; k < 100; k++) begin
      w = '0;
      for (int j = 0; j < 13; j++) w = {w[WW-33:0], 32'($urandom)};
      exp_q.push_back(w);
      @(negedge clk);
      ww = w; vw = 1'b1;
      budget = 0;
      acc = 1'b0;
      while (!acc && budget < 1000) begin
        #1;
        acc = rw;
        if (!acc) @(negedge clk);
        budget++;
      end
      if (!acc) begin
        n_checks++;
        n_fail++;
        $display("FAIL loopback_accept%0d: got no handshake, required one within 1000 cycles", k);
        break;
      end
    end
    @(negedge clk);
    vw = 1'b0;
    budget = 0;
    while (rx_count < 100 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    n_checks++;
    if (rx_count !== 100) begin
      n_fail++;
      $display("FAIL loopback_count: got %0d words, required 100", rx_count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rx_count = 0;
    rx_sr    = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_reset_midword();
    test_clr();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
